// File: rtl/sdram_master_cmd_engine.sv
// SDRAM command engine: valid/ready command channel to registered SDRAM pins,
// with per-command timing and CAS-aligned read return. Optional internal refresh: SDRAM_MASTER_AUTO_REFRESH_EN.
module sdram_master_cmd_engine #(
  parameter int ADDR_WIDTH       = 11,
  parameter int DATA_WIDTH       = 16,
  parameter int BANKSEL_WIDTH    = 2,
  parameter int DQM_WIDTH        = 2,
  parameter int CAS_LATENCY      = 2,
  parameter int T_RCD            = 2,
  parameter int T_RP             = 2,
  parameter int T_RFC            = 7,
  parameter int T_MRD            = 2,
  parameter int REFRESH_INTERVAL = 1560
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [BANKSEL_WIDTH-1:0] req_bs,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [DQM_WIDTH-1:0]     req_dqm,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     refresh_busy,
  output logic                     cke,
  output logic                     cs_n,
  output logic                     ras_n,
  output logic                     cas_n,
  output logic                     we_n,
  output logic [BANKSEL_WIDTH-1:0] bs,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic [DQM_WIDTH-1:0]     dqm,
  output logic [DATA_WIDTH-1:0]    dq_o,
  output logic                     dq_oe,
  input  logic [DATA_WIDTH-1:0]    dq_i
);

  localparam int T_AB  = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int T_CD  = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int T_MAX = (T_AB > T_CD) ? T_AB : T_CD;
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] W_RCD   = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] W_RP    = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] W_RFC   = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] W_MRD   = CNT_W'(T_MRD - 1);

  if (ADDR_WIDTH < 11 || CAS_LATENCY < 1 || CAS_LATENCY > 3 || T_RCD < 1 || T_RP < 1 ||
      T_RFC < 1 || T_MRD < 1 || REFRESH_INTERVAL < 2) begin : g_bad_param
    $error("sdram_master_cmd_engine: parameter out of range");
  end

  typedef enum logic [2:0] {
    OP_NOP = 3'd0, OP_ACT = 3'd1, OP_RD = 3'd2, OP_WR = 3'd3,
    OP_PRE = 3'd4, OP_PALL = 3'd5, OP_REF = 3'd6, OP_LMR = 3'd7
  } op_e;

`ifdef SDRAM_MASTER_AUTO_REFRESH_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_REFRESH = 2'd2} state_e;
`else
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;
`endif

  function automatic logic [CNT_W-1:0] wait_for(input logic [2:0] op);
    case (op)
      OP_ACT:          wait_for = W_RCD;
      OP_PRE, OP_PALL: wait_for = W_RP;
      OP_REF:          wait_for = W_RFC;
      OP_LMR:          wait_for = W_MRD;
      default:         wait_for = '0;
    endcase
  endfunction

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d, acc_wait;
  logic                     started_q, started_d;
  logic                     is_read_q, is_read_d;
  logic [CAS_LATENCY-1:0]   pipe_q, pipe_d, pipe_shift;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                     cs_n_q, cs_n_d, ras_n_q, ras_n_d, cas_n_q, cas_n_d, we_n_q, we_n_d;
  logic [BANKSEL_WIDTH-1:0] bs_q, bs_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DQM_WIDTH-1:0]     dqm_q, dqm_d;
  logic [DATA_WIDTH-1:0]    dq_o_q, dq_o_d;
  logic                     dq_oe_q, dq_oe_d;
  logic                     inflight, hazard, accept;
  logic                     iss_en;
  logic [2:0]               iss_op;
  logic [BANKSEL_WIDTH-1:0] iss_bs;
  logic [ADDR_WIDTH-1:0]    iss_addr;
  logic [DATA_WIDTH-1:0]    iss_wdata;
  logic [DQM_WIDTH-1:0]     iss_dqm;

`ifdef SDRAM_MASTER_AUTO_REFRESH_EN
  localparam int IC_W = $clog2(REFRESH_INTERVAL);
  localparam logic [IC_W-1:0] IC_LAST = IC_W'(REFRESH_INTERVAL - 1);
  logic [IC_W-1:0] ic_q, ic_d;
  logic            pending_q, pending_d, busy_q, busy_d, step_q, step_d, ar_q, ar_d, ref_start;
  assign refresh_busy = busy_q;
`else
  assign refresh_busy = 1'b0;
`endif

  // The read-tracking shift register is fed by the READ currently on the pins.
  if (CAS_LATENCY == 1) begin : g_cl1
    assign pipe_shift = is_read_q;
  end else begin : g_cln
    assign pipe_shift = {pipe_q[CAS_LATENCY-2:0], is_read_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    inflight  = is_read_q | (|pipe_q);
    hazard    = inflight & ((req_op == OP_WR) | (req_op == OP_LMR) |
                            (req_op == OP_PALL) | (req_op == OP_REF));
    req_ready = ~reset & (state_q == S_IDLE) & ~hazard;
`ifdef SDRAM_MASTER_AUTO_REFRESH_EN
    req_ready = req_ready & ~pending_q;
`endif
    accept    = req_valid & req_ready;
    acc_wait  = wait_for(req_op);
    iss_en    = accept;
    iss_op    = req_op;
    iss_bs    = req_bs;
    iss_addr  = req_addr;
    iss_wdata = req_wdata;
    iss_dqm   = req_dqm;

    if (state_q == S_WAIT) begin
      cnt_d   = cnt_q - CNT_ONE;
      state_d = (cnt_q == CNT_ONE) ? S_IDLE : S_WAIT;
    end else if (accept) begin
      cnt_d   = acc_wait;
      state_d = (acc_wait != '0) ? S_WAIT : S_IDLE;
    end else begin
      cnt_d   = cnt_q;
    end

`ifdef SDRAM_MASTER_AUTO_REFRESH_EN
    // Refresh waits for an idle engine with no read data still due back.
    ref_start = pending_q & (state_q == S_IDLE) & ~inflight;
    busy_d    = busy_q;
    step_d    = step_q;
    ar_d      = 1'b0;
    ic_d      = ar_q ? '0 : ((ic_q == IC_LAST) ? ic_q : ic_q + IC_W'(1));
    pending_d = ref_start ? 1'b0 : (pending_q | ((ic_q == IC_LAST) & (state_q != S_REFRESH)));
    if (ref_start) begin
      iss_en = 1'b1; iss_op = OP_PALL; iss_bs = '0; iss_addr = '0; iss_wdata = '0; iss_dqm = '0;
      state_d = S_REFRESH; cnt_d = W_RP; step_d = 1'b0; busy_d = 1'b1;
    end else if (state_q == S_REFRESH) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_ONE;
      end else if (!step_q) begin
        iss_en = 1'b1; iss_op = OP_REF; iss_bs = '0; iss_addr = '0; iss_wdata = '0; iss_dqm = '0;
        cnt_d = W_RFC; step_d = 1'b1; ar_d = 1'b1;
      end else begin
        state_d = S_IDLE; busy_d = 1'b0;
      end
    end else begin
      busy_d = busy_q;
    end
`endif

    started_d = started_q | iss_en;
    cs_n_d    = ~(started_q | iss_en);
    ras_n_d   = 1'b1;
    cas_n_d   = 1'b1;
    we_n_d    = 1'b1;
    bs_d      = '0;
    addr_d    = '0;
    dqm_d     = '0;
    dq_o_d    = '0;
    dq_oe_d   = 1'b0;
    is_read_d = 1'b0;
    if (iss_en) begin
      case (iss_op)
        OP_ACT:  begin ras_n_d = 1'b0; bs_d = iss_bs; addr_d = iss_addr; end
        OP_RD:   begin cas_n_d = 1'b0; bs_d = iss_bs; addr_d = iss_addr; dqm_d = iss_dqm; is_read_d = 1'b1; end
        OP_WR:   begin
          cas_n_d = 1'b0; we_n_d = 1'b0; bs_d = iss_bs; addr_d = iss_addr;
          dqm_d = iss_dqm; dq_o_d = iss_wdata; dq_oe_d = 1'b1;
        end
        OP_PRE:  begin ras_n_d = 1'b0; we_n_d = 1'b0; bs_d = iss_bs; addr_d = iss_addr; addr_d[10] = 1'b0; end
        OP_PALL: begin ras_n_d = 1'b0; we_n_d = 1'b0; bs_d = iss_bs; addr_d = iss_addr; addr_d[10] = 1'b1; end
        OP_REF:  begin ras_n_d = 1'b0; cas_n_d = 1'b0; end
        OP_LMR:  begin ras_n_d = 1'b0; cas_n_d = 1'b0; we_n_d = 1'b0; addr_d = iss_addr; end
        default: begin ras_n_d = 1'b1; end
      endcase
    end else begin
      is_read_d = 1'b0;
    end

    pipe_d      = pipe_shift;
    rsp_valid_d = pipe_q[CAS_LATENCY-1];
    rsp_rdata_d = pipe_q[CAS_LATENCY-1] ? dq_i : rsp_rdata_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE; cnt_q <= '0; started_q <= 1'b0; is_read_q <= 1'b0; pipe_q <= '0;
      rsp_valid_q <= 1'b0; rsp_rdata_q <= '0;
      cs_n_q <= 1'b1; ras_n_q <= 1'b1; cas_n_q <= 1'b1; we_n_q <= 1'b1;
      bs_q <= '0; addr_q <= '0; dqm_q <= '0; dq_o_q <= '0; dq_oe_q <= 1'b0;
`ifdef SDRAM_MASTER_AUTO_REFRESH_EN
      ic_q <= '0; pending_q <= 1'b0; busy_q <= 1'b0; step_q <= 1'b0; ar_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; started_q <= started_d; is_read_q <= is_read_d; pipe_q <= pipe_d;
      rsp_valid_q <= rsp_valid_d; rsp_rdata_q <= rsp_rdata_d;
      cs_n_q <= cs_n_d; ras_n_q <= ras_n_d; cas_n_q <= cas_n_d; we_n_q <= we_n_d;
      bs_q <= bs_d; addr_q <= addr_d; dqm_q <= dqm_d; dq_o_q <= dq_o_d; dq_oe_q <= dq_oe_d;
`ifdef SDRAM_MASTER_AUTO_REFRESH_EN
      ic_q <= ic_d; pending_q <= pending_d; busy_q <= busy_d; step_q <= step_d; ar_q <= ar_d;
`endif
    end
  end

  assign cke       = 1'b1;
  assign cs_n      = cs_n_q;
  assign ras_n     = ras_n_q;
  assign cas_n     = cas_n_q;
  assign we_n      = we_n_q;
  assign bs        = bs_q;
  assign addr      = addr_q;
  assign dqm       = dqm_q;
  assign dq_o      = dq_o_q;
  assign dq_oe     = dq_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sdram_master_cmd_engine.sv
// Directed bench for sdram_master_cmd_engine: per-cycle vector table plus
// read/write pipelining and reset-mid-read sequences against a small SDRAM read model.
module tb_sdram_master_cmd_engine;
  localparam int CL = 2;

  logic        clock = 1'b0;
  logic        reset, req_valid, req_ready;
  logic [2:0]  req_op;
  logic [1:0]  req_bs, req_dqm, bs, dqm;
  logic [10:0] req_addr, addr;
  logic [15:0] req_wdata, rsp_rdata, dq_o, dq_i;
  logic        rsp_valid, refresh_busy, cke, cs_n, ras_n, cas_n, we_n, dq_oe;
  logic [3:0]  cmd;

  always #5 clock = ~clock;

  sdram_master_cmd_engine #(
    .ADDR_WIDTH(11), .DATA_WIDTH(16), .BANKSEL_WIDTH(2), .DQM_WIDTH(2), .CAS_LATENCY(CL),
    .T_RCD(2), .T_RP(2), .T_RFC(7), .T_MRD(2), .REFRESH_INTERVAL(1560)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_bs(req_bs), .req_addr(req_addr), .req_wdata(req_wdata), .req_dqm(req_dqm),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .refresh_busy(refresh_busy),
    .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .bs(bs), .addr(addr), .dqm(dqm), .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i)
  );

  assign cmd = {cs_n, ras_n, cas_n, we_n};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] rd_model(input logic [10:0] a);
    rd_model = 16'hBEEF + {5'd0, a} - 16'h0008;
  endfunction

  // SDRAM read model and pin monitor, sampled mid-cycle.
  logic [15:0] sched_d [8];
  logic        sched_v [8];
  int          act_cyc, wr_cyc, oe_bad;
  logic        wr_oe;
  logic [15:0] wr_dq;
  logic [1:0]  wr_dqm;
  int          rd_cyc [$];
  int          rsp_cyc [$];
  logic [15:0] rsp_dat [$];

  initial begin
    act_cyc = -100; wr_cyc = -100; oe_bad = 0; wr_oe = 1'b0; wr_dq = 16'h0; wr_dqm = 2'b00; dq_i = 16'h0;
    for (int k = 0; k < 8; k++) begin sched_v[k] = 1'b0; sched_d[k] = 16'h0; end
    forever begin
      @(negedge clock);
      if (reset) begin
        for (int k = 0; k < 8; k++) sched_v[k] = 1'b0;
        dq_i = 16'h0;
      end else begin
        if (sched_v[cyc % 8]) begin dq_i = sched_d[cyc % 8]; sched_v[cyc % 8] = 1'b0; end
        else dq_i = 16'h0;
        if (cmd == 4'b0011) act_cyc = cyc;
        if (cmd == 4'b0101) begin
          rd_cyc.push_back(cyc);
          sched_v[(cyc + CL) % 8] = 1'b1;
          sched_d[(cyc + CL) % 8] = rd_model(addr);
        end
        if (cmd == 4'b0100) begin wr_cyc = cyc; wr_oe = dq_oe; wr_dq = dq_o; wr_dqm = dqm; end
        else if (dq_oe) oe_bad = oe_bad + 1;
      end
      if (rsp_valid) begin rsp_cyc.push_back(cyc); rsp_dat.push_back(rsp_rdata); end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] b, input logic [10:0] a,
                       input logic [15:0] wd, input logic [1:0] m);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1; req_op = op; req_bs = b; req_addr = a; req_wdata = wd; req_dqm = m;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout op=%0d: got no req_ready expected req_ready within 50 cycles", op);
    end
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [1:0]  b;
    logic [10:0] a;
    logic        rdy;
    logic [3:0]  cmd;
    logic [1:0]  eb;
    logic [10:0] ea;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [2:0] op, input logic [1:0] b, input logic [10:0] a,
                              input logic rdy, input logic [3:0] c, input logic [1:0] eb, input logic [10:0] ea);
    mk = '{v, op, b, a, rdy, c, eb, ea};
  endfunction

  vec_t tbl [$];
  int   ra, sa;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_bs = 2'd0; req_addr = 11'd0;
    req_wdata = 16'd0; req_dqm = 2'd0;

    // Per-cycle table: inputs presented, then ready and pins checked mid-cycle.
    tbl.push_back(mk(1'b0, 3'd0, 2'd0, 11'h000, 1'b1, 4'b1111, 2'd0, 11'h000));
    tbl.push_back(mk(1'b1, 3'd7, 2'd3, 11'h020, 1'b1, 4'b1111, 2'd0, 11'h000));
    tbl.push_back(mk(1'b1, 3'd0, 2'd0, 11'h000, 1'b0, 4'b0000, 2'd0, 11'h020));
    tbl.push_back(mk(1'b1, 3'd0, 2'd0, 11'h000, 1'b1, 4'b0111, 2'd0, 11'h000));
    tbl.push_back(mk(1'b1, 3'd4, 2'd2, 11'h7FF, 1'b1, 4'b0111, 2'd0, 11'h000));
    tbl.push_back(mk(1'b1, 3'd5, 2'd0, 11'h000, 1'b0, 4'b0010, 2'd2, 11'h3FF));
    tbl.push_back(mk(1'b1, 3'd5, 2'd0, 11'h000, 1'b1, 4'b0111, 2'd0, 11'h000));
    tbl.push_back(mk(1'b1, 3'd1, 2'd1, 11'h155, 1'b0, 4'b0010, 2'd0, 11'h400));
    tbl.push_back(mk(1'b1, 3'd1, 2'd1, 11'h155, 1'b1, 4'b0111, 2'd0, 11'h000));
    tbl.push_back(mk(1'b1, 3'd6, 2'd0, 11'h000, 1'b0, 4'b0011, 2'd1, 11'h155));
    tbl.push_back(mk(1'b1, 3'd6, 2'd0, 11'h000, 1'b1, 4'b0111, 2'd0, 11'h000));
    tbl.push_back(mk(1'b0, 3'd0, 2'd0, 11'h000, 1'b0, 4'b0001, 2'd0, 11'h000));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b0, 3'd0, 2'd0, 11'h000, 1'b0, 4'b0111, 2'd0, 11'h000));
    tbl.push_back(mk(1'b0, 3'd0, 2'd0, 11'h000, 1'b1, 4'b0111, 2'd0, 11'h000));

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_values", {cke, cs_n, ras_n, cas_n, we_n, bs, addr, dqm, dq_o, dq_oe, rsp_valid, rsp_rdata,
                         refresh_busy, req_ready}, {5'b11111, 51'd0});
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      req_valid = tbl[i].v; req_op = tbl[i].op; req_bs = tbl[i].b; req_addr = tbl[i].a;
      @(negedge clock);
      chk($sformatf("vec%0d", i), {req_ready, cmd, bs, addr, dq_oe},
          {tbl[i].rdy, tbl[i].cmd, tbl[i].eb, tbl[i].ea, 1'b0});
      @(posedge clock); #1;
    end
    req_valid = 1'b0;

    // ACTIVATE followed by a READ held valid.
    ra = rd_cyc.size(); sa = rsp_cyc.size();
    issue(3'd1, 2'd1, 11'h155, 16'h0, 2'd0);
    issue(3'd2, 2'd1, 11'h008, 16'h0, 2'd0);
    repeat (6) @(posedge clock); #1;
    chk("act_read_count", 64'(rd_cyc.size() - ra), 64'd1);
    chk("act_to_read", 64'(rd_cyc[ra] - act_cyc), 64'd2);
    chk("read_rsp_count", 64'(rsp_cyc.size() - sa), 64'd1);
    chk("read_rsp_lat", 64'(rsp_cyc[sa] - rd_cyc[ra]), 64'(CL + 1));
    chk("read_rsp_data", {48'd0, rsp_dat[sa]}, 64'hBEEF);

    // Four pipelined READs, then a WRITE that must wait for the read pipe to drain.
    ra = rd_cyc.size(); sa = rsp_cyc.size();
    for (int i = 0; i < 4; i++) issue(3'd2, 2'd1, 11'(i), 16'h0, 2'd0);
    issue(3'd3, 2'd1, 11'h010, 16'h1234, 2'b01);
    repeat (8) @(posedge clock); #1;
    chk("b2b_read_count", 64'(rd_cyc.size() - ra), 64'd4);
    chk("b2b_rsp_count", 64'(rsp_cyc.size() - sa), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_read_cycle%0d", i), 64'(rd_cyc[ra + i] - rd_cyc[ra]), 64'(i));
      chk($sformatf("b2b_rsp_cycle%0d", i), 64'(rsp_cyc[sa + i] - rd_cyc[ra + i]), 64'(CL + 1));
      chk($sformatf("b2b_rsp_data%0d", i), {48'd0, rsp_dat[sa + i]}, 64'(16'hBEE7 + 16'(i)));
    end
    chk("write_after_drain", 64'(wr_cyc - rd_cyc[ra + 3]), 64'(CL + 2));
    chk("write_bus", {wr_oe, wr_dq, wr_dqm}, {1'b1, 16'h1234, 2'b01});
    chk("dq_oe_outside_write", 64'(oe_bad), 64'd0);

    // Reset lands while a READ is in flight: pins deselect, no response appears.
    sa = rsp_cyc.size();
    issue(3'd2, 2'd0, 11'h005, 16'h0, 2'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("midreset_pins", {req_ready, cmd, dq_oe, rsp_valid}, {1'b0, 4'b1111, 1'b0, 1'b0});
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("no_stale_rsp", 64'(rsp_cyc.size() - sa), 64'd0);
    chk("post_reset_idle", {req_ready, cmd, refresh_busy}, {1'b1, 4'b1111, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
